// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, registers {pc_next, instr, valid} for IF/ID.
// Latency: one request cycle plus the memory latency; results appear the cycle after the ack. At most one fetch per 2 cycles.
// Backpressure: enable=0 freezes the outputs, and a word fetched during a stall is parked until enable returns. Optional IF_PERF_CNT_EN adds fetch/bubble counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_next_out,
    output logic [31:0] instr_out,
    output logic        instr_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        kill;
    logic        hold_valid;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    logic        ack_hit;
    logic        take;
    logic        park;
    logic        issue;
    logic        load_word;
    logic [31:0] ack_pc_next;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. A redirect while waiting keeps the bus request alive, so the address stays put until the ack.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = (state == S_WAIT && !imem_ack) ? S_WAIT : S_REQ;
        end else begin
            case (state)
                S_REQ:   state_nxt = S_WAIT;
                S_WAIT:  if (imem_ack) state_nxt = (kill || enable) ? S_REQ : S_HOLD;
                S_HOLD:  if (enable) state_nxt = S_REQ;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // Bus request and the per-cycle decode of what happens to the fetched word.
    always_comb begin
        imem_req    = (state == S_WAIT);
        ack_hit     = (state == S_WAIT) && imem_ack;
        take        = ack_hit && !kill && !redirect_valid;
        park        = take && !enable;
        issue       = (state == S_REQ) && !redirect_valid;
        load_word   = enable && !redirect_valid && (take || (state == S_HOLD && hold_valid));
        ack_pc_next = imem_addr + 32'd4;
    end

    // PC, request address and the kill flag for a fetch made stale by a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            imem_addr <= 32'h0000_0000;
            kill      <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (take) begin
                pc <= ack_pc_next;
            end
            if (issue) begin
                imem_addr <= pc;
            end
            if (redirect_valid) begin
                kill <= (state == S_WAIT) && !imem_ack;
            end else if (ack_hit) begin
                kill <= 1'b0;
            end
        end
    end

    // Park buffer for a word that arrives while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= 32'h0000_0000;
        end else begin
            if (redirect_valid) begin
                hold_valid <= 1'b0;
            end else if (park) begin
                hold_valid <= 1'b1;
                hold_instr <= imem_rdata;
                hold_pc    <= ack_pc_next;
            end else if (load_word) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // IF/ID-facing output register: frozen on stall, else a real word or a bubble with pc_next held.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_next_out <= 32'h0000_0000;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (enable) begin
            if (load_word) begin
                pc_next_out <= take ? ack_pc_next : hold_pc;
                instr_out   <= take ? imem_rdata  : hold_instr;
                instr_valid <= 1'b1;
            end else begin
                instr_out   <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters: accepted fetches and bubbles actually loaded downstream; both wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= 32'h0000_0000;
            bubble_count <= 32'h0000_0000;
        end else begin
            if (take) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (enable && !load_word) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: random memory latency, stalls and redirects against a word-level reference model.
// The model tracks only the next expected fetch address and at most one fetched-but-undelivered word.
// Inputs change #1 after the rising edge; outputs are sampled at the same point, reflecting the previous cycle.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_next_out;
    logic [31:0] instr_out;
    logic        instr_valid;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_next_out   (pc_next_out),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pcn;
    bit          pend_n;
    logic [31:0] pend_pc;
    logic [31:0] pend_instr;
    logic [31:0] exp_fetch;

    // What was driven during the previous cycle.
    bit          p_reset = 1'b1;
    bit          p_enable;
    bit          p_redirect;
    logic [31:0] p_rpc;
    bit          p_accept;
    bit          p_ack;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    bit          prev_req;
    logic [31:0] prev_addr;

    // Memory responder and stimulus knobs.
    int          wait_cnt = -1;
    bit          tainted;
    int          lat_min, lat_max, p_en, p_rd;
    int          force_rst;
    bit          hook_rst, hook_20, oneshot_rd;
    logic [31:0] oneshot_pc;
    int          rst_fired, h20_fired;
    int          cov_wrap, cov_rd_ack, cov_rd_hold, cov_kill, n_valid_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [7:0] w;
        w = 8'($urandom_range(255, 0));
        case ($urandom_range(3, 0))
            0:       return 32'h0000_0100;
            1:       return 32'hFFFF_FFF4;
            2:       return {22'd0, w, 2'b00};
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        bit          ack_now, rd_now, rst_now, acc_now;
        logic [31:0] rpc_now;
        logic [31:0] data_now;
        @(posedge clk);
        #1;
        // Advance the model by what happened in the previous cycle.
        if (p_reset) begin
            m_valid   = 1'b0;
            m_instr   = NOP;
            m_pcn     = 32'h0;
            pend_n    = 1'b0;
            exp_fetch = RST_PC;
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_addr", imem_addr, 32'h0);
        end else begin
            if (p_redirect) begin
                pend_n    = 1'b0;
                exp_fetch = p_rpc;
            end
            if (p_accept) begin
                pend_n     = 1'b1;
                pend_pc    = p_addr + 32'd4;
                pend_instr = p_data;
                exp_fetch  = p_addr + 32'd4;
            end
            if (p_enable) begin
                if (!p_redirect && pend_n) begin
                    m_valid = 1'b1;
                    m_instr = pend_instr;
                    m_pcn   = pend_pc;
                    pend_n  = 1'b0;
                    n_valid_out++;
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end
            end
        end
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("instr_out", instr_out, m_instr);
        chk("pc_next_out", pc_next_out, m_pcn);
        if (pend_n) chk("parked_req_low", {31'd0, imem_req}, 32'd0);
        if (!p_reset && prev_req && !p_ack) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, prev_addr);
        end

        // Memory responder.
        ack_now  = 1'b0;
        data_now = $urandom;
        if (imem_req) begin
            if (wait_cnt < 0) wait_cnt = $urandom_range(lat_max, lat_min);
            if (wait_cnt == 0) begin
                ack_now  = 1'b1;
                data_now = memf(imem_addr);
                wait_cnt = -1;
            end else begin
                wait_cnt--;
            end
        end else begin
            wait_cnt = -1;
        end

        // Control stimulus.
        rst_now = (force_rst > 0);
        if (force_rst > 0) force_rst--;
        if (hook_rst && imem_req) begin
            rst_now  = 1'b1;
            hook_rst = 1'b0;
            rst_fired++;
        end
        rd_now  = ($urandom_range(99, 0) < p_rd);
        rpc_now = pick_target();
        if (hook_20 && imem_req && !ack_now && imem_addr == 32'h20) begin
            rd_now  = 1'b1;
            rpc_now = 32'h100;
            hook_20 = 1'b0;
            h20_fired++;
        end
        if (oneshot_rd) begin
            rd_now     = 1'b1;
            rpc_now    = oneshot_pc;
            oneshot_rd = 1'b0;
        end

        acc_now = ack_now && !tainted && !rd_now && !rst_now;
        if (acc_now) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            if (imem_addr == 32'hFFFF_FFFC) cov_wrap++;
        end
        if (!rst_now && rd_now && ack_now) cov_rd_ack++;
        if (!rst_now && rd_now && pend_n) cov_rd_hold++;
        if (!rst_now && rd_now && imem_req && !ack_now) cov_kill++;
        if (rst_now || ack_now) tainted = 1'b0;
        else if (rd_now && imem_req) tainted = 1'b1;
        if (rst_now) wait_cnt = -1;

        reset          = rst_now;
        enable         = ($urandom_range(99, 0) < p_en);
        redirect_valid = rd_now;
        redirect_pc    = rpc_now;
        imem_ack       = ack_now;
        imem_rdata     = data_now;

        p_reset    = rst_now;
        p_enable   = enable;
        p_redirect = rd_now;
        p_rpc      = rpc_now;
        p_accept   = acc_now;
        p_ack      = ack_now;
        p_addr     = imem_addr;
        p_data     = data_now;
        prev_req   = imem_req;
        prev_addr  = imem_addr;
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        force_rst      = 2;

        // Zero-latency memory, always enabled: straight-line fetch from RESET_PC.
        lat_min = 0; lat_max = 0; p_en = 100; p_rd = 0;
        repeat (40) step();

        // Fixed 3-cycle latency.
        lat_min = 3; lat_max = 3;
        repeat (40) step();

        // Reset while a request is outstanding.
        lat_min = 2; lat_max = 3;
        hook_rst = 1'b1;
        repeat (10) step();
        chk("rst_hook_fired", 32'(rst_fired), 32'd1);

        // Redirect to 0x100 while waiting on 0x20.
        lat_min = 3; lat_max = 3;
        hook_20 = 1'b1;
        repeat (80) step();
        chk("redir20_fired", 32'(h20_fired), 32'd1);

        // Stall windows of 5 cycles across variable latency.
        lat_min = 0; lat_max = 3;
        repeat (5) begin
            p_en = 100; repeat (4) step();
            p_en = 0;   repeat (5) step();
        end
        p_en = 100;

        // PC wrap-around at the top of the address space.
        lat_min = 0; lat_max = 1;
        oneshot_rd = 1'b1; oneshot_pc = 32'hFFFF_FFF4;
        repeat (25) step();

        // Random mix of latency, stalls and redirects.
        lat_min = 0; lat_max = 3; p_en = 70; p_rd = 6;
        repeat (2000) step();
        p_rd = 0;
        repeat (10) step();

        chk("cov_wrap", (cov_wrap > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("cov_redirect_with_ack", (cov_rd_ack > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("cov_redirect_in_hold", (cov_rd_hold > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("cov_redirect_in_wait", (cov_kill > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("cov_valid_outputs", (n_valid_out > 100) ? 32'd1 : 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
